hier_leaf_skid_stage: RTL

//  Leaf pipeline stage for the generated hierarchy leaves (the sf9_* level); composite parents instantiate it as the data path.

---
 rtl/hier_leaf_pkg.sv | 12 +
 rtl/hier_leaf_sig_accum.sv | 31 +++
 rtl/hier_leaf_skid_stage.sv | 93 +++++++++
 3 files changed

// File: rtl/hier_leaf_pkg.sv
// Shared types and defaults for the sf9_* hierarchy leaf stage and its signature accumulator.
package hier_leaf_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } skid_state_t;

  localparam logic [31:0] HIER_SIG_SEED = 32'hA5A5_A5A5;

endpackage

// File: rtl/hier_leaf_sig_accum.sv
// Rotate-XOR signature and saturating beat counter over delivered beats.
// Parent checkers reuse this module to fold a whole subtree into one word.
module hier_leaf_sig_accum
  import hier_leaf_pkg::*;
#(
  parameter int               DATA_W   = 32,
  parameter int               CNT_W    = 16,
  parameter logic [DATA_W-1:0] SIG_SEED = HIER_SIG_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              fire,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] sig,
  output logic [CNT_W-1:0]  beat_cnt
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      // clr outranks a coincident transfer: that beat is neither folded in nor counted.
      sig      <= SIG_SEED;
      beat_cnt <= '0;
    end else if (fire) begin
      sig <= {sig[DATA_W-2:0], sig[DATA_W-1]} ^ data;
      if (beat_cnt != {CNT_W{1'b1}}) beat_cnt <= beat_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hier_leaf_skid_stage.sv
// Registered valid/ready leaf stage with a 2-entry skid buffer (out reg + skid reg).
// in_ready is a flop, so the upstream ready path never sees out_ready combinationally.
module hier_leaf_skid_stage
  import hier_leaf_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                CNT_W    = 16,
  parameter logic [DATA_W-1:0] SIG_SEED = HIER_SIG_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sig,
  output logic [CNT_W-1:0]  beat_cnt,
  input  logic              clr
);

  skid_state_t       state;
  logic [DATA_W-1:0] skid_data;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      in_ready  <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          in_ready <= 1'b1;
          if (in_fire) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            out_data <= in_data;
          end else if (out_fire) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end else if (in_fire) begin
            in_ready <= 1'b0;
            state    <= ST_TWO;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            out_data <= skid_data;
            in_ready <= 1'b1;
            state    <= ST_ONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
          state     <= ST_EMPTY;
        end
      endcase
    end
  end

  // NOTE: the skid reg is data-only storage; the FSM guards its contents, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == ST_ONE && in_fire && !out_fire) skid_data <= in_data;
  end

  hier_leaf_sig_accum #(
    .DATA_W  (DATA_W),
    .CNT_W   (CNT_W),
    .SIG_SEED(SIG_SEED)
  ) u_sig_accum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .fire    (out_fire),
    .data    (out_data),
    .sig     (sig),
    .beat_cnt(beat_cnt)
  );

endmodule
